// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths, FSM encoding and read-pipeline entry for the SRAM responder
package sram_pkg;

  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_ADDR_W = 18;
  localparam logic [SRAM_DATA_W-1:0] SRAM_CLEAR_VAL = 16'h0000;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } sram_state_e;

  typedef struct packed {
    logic                   valid;
    logic [SRAM_DATA_W-1:0] data;
    logic                   ub;
    logic                   lb;
  } rd_entry_t;

endpackage

// File: rtl/sram_resp_pipe.sv
// rtl/sram_resp_pipe.sv - LAT-stage register chain carrying read results toward the DQ drivers
module sram_resp_pipe
  import sram_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  rd_entry_t entry_i,
  output rd_entry_t entry_o
);

  logic [LAT-1:0]         valid_q;
  logic [LAT-1:0]         ub_q;
  logic [LAT-1:0]         lb_q;
  logic [SRAM_DATA_W-1:0] data_q [LAT];

  // Only the valid bits need reset; payload is ignored while valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= entry_i.valid;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    data_q[0] <= entry_i.data;
    ub_q[0]   <= entry_i.ub;
    lb_q[0]   <= entry_i.lb;
    for (int i = 1; i < LAT; i++) begin
      data_q[i] <= data_q[i-1];
      ub_q[i]   <= ub_q[i-1];
      lb_q[i]   <= lb_q[i-1];
    end
  end

  assign entry_o.valid = valid_q[LAT-1];
  assign entry_o.data  = data_q[LAT-1];
  assign entry_o.ub    = ub_q[LAT-1];
  assign entry_o.lb    = lb_q[LAT-1];

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - on-chip stand-in for the external 16-bit async SRAM on the controller's pins
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DEPTH_W  = 10,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_req,
  input  logic [ADDR_W-1:0]      SRAM_ADDR,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  input  logic                   SRAM_UB_N,
  input  logic                   SRAM_LB_N,
  input  logic                   SRAM_WE_N,
  input  logic                   SRAM_CE_N,
  input  logic                   SRAM_OE_N,
  output logic                   busy,
  output logic [CNT_W-1:0]       wr_count,
  output logic [CNT_W-1:0]       rd_count
);

  localparam int WORDS = 1 << DEPTH_W;

  sram_state_e            state_q, state_d;
  logic [DEPTH_W-1:0]     clr_idx_q, clr_idx_d;
  logic [CNT_W-1:0]       wr_count_q, wr_count_d;
  logic [CNT_W-1:0]       rd_count_q, rd_count_d;
  logic [SRAM_DATA_W-1:0] mem [WORDS];

  logic [DEPTH_W-1:0] idx;
  logic               wr_en;
  logic               rd_launch;
  logic               unused_addr;
  rd_entry_t          pipe_in;
  rd_entry_t          pipe_out;
  logic               dq_oe_hi;
  logic               dq_oe_lo;

  // Upper address bits alias onto the implemented words.
  assign idx         = SRAM_ADDR[DEPTH_W-1:0];
  assign unused_addr = ^SRAM_ADDR[ADDR_W-1:DEPTH_W];

  assign wr_en     = (state_q == RUN) && !SRAM_CE_N && !SRAM_WE_N;
  assign rd_launch = (state_q == RUN) && !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    case (state_q)
      CLEAR: begin
        if (clear_req) begin
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
          if (clr_idx_q == {DEPTH_W{1'b1}}) state_d = RUN;
        end
      end
      RUN: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
    if (wr_en && wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
    if (rd_launch && rd_count_q != '1) rd_count_d = rd_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CLEAR;
      clr_idx_q  <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_idx_q] <= SRAM_CLEAR_VAL;
    end else if (wr_en) begin
      if (!SRAM_UB_N) mem[idx][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) mem[idx][7:0]  <= SRAM_DQ[7:0];
    end
  end

  // Launch and write are exclusive on an edge, so the array read already sees prior writes.
  assign pipe_in.valid = rd_launch;
  assign pipe_in.data  = mem[idx];
  assign pipe_in.ub    = ~SRAM_UB_N;
  assign pipe_in.lb    = ~SRAM_LB_N;

  sram_resp_pipe #(.LAT(READ_LAT)) u_pipe (
    .clk     (clk),
    .rst_n   (rst),
    .entry_i (pipe_in),
    .entry_o (pipe_out)
  );

  // Drive gates on live pins so a late WE_N or OE_N change releases the bus at once.
  assign dq_oe_hi = pipe_out.valid & pipe_out.ub & ~SRAM_CE_N & ~SRAM_OE_N & SRAM_WE_N;
  assign dq_oe_lo = pipe_out.valid & pipe_out.lb & ~SRAM_CE_N & ~SRAM_OE_N & SRAM_WE_N;

  assign SRAM_DQ[15:8] = dq_oe_hi ? pipe_out.data[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = dq_oe_lo ? pipe_out.data[7:0]  : 8'hzz;

  assign busy     = (state_q == CLEAR);
  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - self-checking bench for sram_responder against an array/counter reference model
module tb_sram_responder;

  localparam int LAT   = 1;
  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear_req = 1'b0;
  logic [17:0] addr = '0;
  logic        ub_n = 1'b1, lb_n = 1'b1, we_n = 1'b1, ce_n = 1'b1, oe_n = 1'b1;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_dq = '0;
  wire  [15:0] sram_dq;
  wire         busy;
  wire  [15:0] wr_count, rd_count;

  assign sram_dq = tb_drv ? tb_dq : 16'hzzzz;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] ref_mem [WORDS];
  int          ref_wr = 0;
  int          ref_rd = 0;

  sram_responder #(.ADDR_W(18), .DEPTH_W(10), .READ_LAT(LAT), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .SRAM_ADDR (addr),
    .SRAM_DQ   (sram_dq),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_WE_N (we_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .busy      (busy),
    .wr_count  (wr_count),
    .rd_count  (rd_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b1; lb_n = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic ref_clear();
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 16'h0000;
  endtask

  task automatic check_dq(input string tag, input logic [15:0] exp, input logic eh, input logic el);
    check({tag, "_oe_hi"}, 32'(dut.dq_oe_hi), 32'(eh));
    check({tag, "_oe_lo"}, 32'(dut.dq_oe_lo), 32'(el));
    if (eh) check({tag, "_dq_hi"}, 32'(sram_dq[15:8]), 32'(exp[15:8]));
    if (el) check({tag, "_dq_lo"}, 32'(sram_dq[7:0]), 32'(exp[7:0]));
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_wr_count"}, 32'(wr_count), 32'(ref_wr));
    check({tag, "_rd_count"}, 32'(rd_count), 32'(ref_rd));
  endtask

  task automatic wait_sweep(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 4000) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n), 32'(WORDS));
    ref_clear();
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic ubn, input logic lbn);
    @(negedge clk);
    addr = a; tb_dq = d; tb_drv = 1'b1; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ub_n = ubn; lb_n = lbn;
    @(posedge clk);
    #1 idle();
    if (!ubn) ref_mem[a[9:0]][15:8] = d[15:8];
    if (!lbn) ref_mem[a[9:0]][7:0]  = d[7:0];
    if (ref_wr < 65535) ref_wr++;
  endtask

  task automatic launch_read(input logic [17:0] a, input logic ubn, input logic lbn);
    @(negedge clk);
    addr = a; tb_drv = 1'b0; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = ubn; lb_n = lbn;
    @(posedge clk);
    if (ref_rd < 65535) ref_rd++;
    #1;
    if (LAT > 1) begin
      oe_n = 1'b1;
      repeat (LAT - 1) @(posedge clk);
      #1 oe_n = 1'b0;
    end
  endtask

  task automatic do_read(input string tag, input logic [17:0] a, input logic ubn, input logic lbn);
    logic [15:0] exp;
    exp = ref_mem[a[9:0]];
    launch_read(a, ubn, lbn);
    #3 check_dq(tag, exp, !ubn, !lbn);
    idle();
  endtask

  initial begin
    logic [17:0] ra;
    logic [15:0] rd;
    logic        rub, rlb;

    idle();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check_counts("rst");
    check("rst_oe", 32'({dut.dq_oe_hi, dut.dq_oe_lo}), 32'd0);

    rst = 1'b1;
    wait_sweep("sweep_after_reset");
    check("busy_after_sweep", 32'(busy), 32'd0);
    do_read("rd_idx5", 18'd5, 1'b0, 1'b0);

    do_write(18'h00012, 16'hA5C3, 1'b0, 1'b0);
    do_read("rd_full", 18'h00012, 1'b0, 1'b0);
    check_counts("after_full");

    do_write(18'd7, 16'h1234, 1'b0, 1'b0);
    do_write(18'd7, 16'hFFFF, 1'b1, 1'b0);
    do_read("rd_bytes", 18'd7, 1'b0, 1'b0);
    do_read("rd_ub_only", 18'd7, 1'b0, 1'b1);

    do_write(18'h00403, 16'hBEEF, 1'b0, 1'b0);
    do_read("rd_alias", 18'h00003, 1'b0, 1'b0);

    // Four reads on consecutive edges; each result appears the cycle after its launch.
    @(negedge clk);
    addr = 18'd0; tb_drv = 1'b0; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      ref_rd++;
      #1 if (k < 3) addr = 18'(k + 1);
      #3 check_dq($sformatf("b2b_%0d", k), ref_mem[k], 1'b1, 1'b1);
    end
    idle();
    check_counts("after_b2b");

    launch_read(18'd7, 1'b0, 1'b0);
    oe_n = 1'b1;
    #3 check_dq("abort_oe", 16'h0000, 1'b0, 1'b0);
    idle();
    launch_read(18'd7, 1'b0, 1'b0);
    we_n = 1'b0;
    #3 check_dq("abort_we", 16'h0000, 1'b0, 1'b0);
    idle();

    @(negedge clk);
    addr = 18'd7; tb_dq = 16'h0000; tb_drv = 1'b1; ce_n = 1'b1; we_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
    @(posedge clk);
    #1 idle();
    check_counts("ce_high_write");
    do_read("rd_ce_hold", 18'd7, 1'b0, 1'b0);

    launch_read(18'd3, 1'b0, 1'b0);
    check("pre_rst_drive", 32'({dut.dq_oe_hi, dut.dq_oe_lo}), 32'd3);
    rst = 1'b0;
    #1 check("rst_mid_read_oe", 32'({dut.dq_oe_hi, dut.dq_oe_lo}), 32'd0);
    idle();
    ref_wr = 0; ref_rd = 0;
    check_counts("rst_mid_read");
    @(negedge clk);
    rst = 1'b1;
    wait_sweep("sweep_after_mid_reset");
    do_read("rd_after_reset", 18'd3, 1'b0, 1'b0);

    do_write(18'd100, 16'h5A5A, 1'b0, 1'b0);
    do_read("rd_before_clear", 18'd100, 1'b0, 1'b0);
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
    @(negedge clk);
    check("clear_busy", 32'(busy), 32'd1);
    wait_sweep("sweep_after_clear");
    do_read("rd_after_clear", 18'd100, 1'b0, 1'b0);
    check_counts("after_clear");

    for (int it = 0; it < 80; it++) begin
      ra  = {8'($urandom), 10'($urandom_range(0, 15))};
      rd  = 16'($urandom);
      rub = 1'($urandom_range(0, 1));
      rlb = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) do_write(ra, rd, rub, rlb);
      else do_read($sformatf("rand_rd_%0d", it), ra, rub, rlb);
    end
    check_counts("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
